// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared execute-stage hazard definitions: forwarding select encodings, the shadow-entry
// layout and the nearest-producer select function used by the controller.
package ex_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 3;

  typedef enum logic [2:0] {
    FwdNone  = 3'd0,
    FwdExMem = 3'd1,
    FwdMemWb = 3'd2,
    FwdWb    = 3'd3
  } fwd_sel_e;

  typedef struct packed {
    logic                v;
    logic [RegAddrW-1:0] rd;
    logic                wr_rd;
    logic                is_load;
    logic                wr_ccr;
  } hz_entry_t;

  localparam hz_entry_t HzBubble = '0;

  // Nearest in-flight producer of rs wins; unused operands never forward.
  function automatic fwd_sel_e fwd_pick(input logic [RegAddrW-1:0] rs,
                                        input logic                use_rs,
                                        input hz_entry_t           ex,
                                        input hz_entry_t           mem,
                                        input hz_entry_t           wb);
    fwd_sel_e sel;
    sel = FwdNone;
    if (use_rs) begin
      if (ex.v && ex.wr_rd && (ex.rd == rs)) begin
        sel = FwdExMem;
      end else if (mem.v && mem.wr_rd && (mem.rd == rs)) begin
        sel = FwdMemWb;
      end else if (wb.v && wb.wr_rd && (wb.rd == rs)) begin
        sel = FwdWb;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Decode-side request and execute-side control bundle of the hazard controller.
interface ex_hazard_ctrl_if #(
  parameter int unsigned RA_W    = 3,
  parameter int unsigned STALL_W = 16
);
  logic               id_valid;
  logic [RA_W-1:0]    id_rs1;
  logic [RA_W-1:0]    id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RA_W-1:0]    id_rd;
  logic               id_wr_rd;
  logic               id_is_load;
  logic               id_wr_ccr;
  logic               flush;
  logic [2:0]         ex_fwd_sel_a;
  logic [2:0]         ex_fwd_sel_b;
  logic               ex_ccr_write;
  logic               id_stall;
  logic               ex_bubble;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd, id_is_load,
           id_wr_ccr, flush,
    input  ex_fwd_sel_a, ex_fwd_sel_b, ex_ccr_write, id_stall, ex_bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_wr_rd, id_is_load,
           id_wr_ccr, flush,
    output ex_fwd_sel_a, ex_fwd_sel_b, ex_ccr_write, id_stall, ex_bubble, stall_count
  );
endinterface

// File: rtl/hz_shadow_stage.sv
// One registered scoreboard entry of the shadow pipeline; clear turns it into a bubble.
module hz_shadow_stage
  import ex_hazard_ctrl_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clr_i,
  input  logic      ld_i,
  input  hz_entry_t d_i,
  output hz_entry_t q_o
);

  hz_entry_t entry_d, entry_q;

  always_comb begin
    entry_d = entry_q;
    if (clr_i) begin
      entry_d = HzBubble;
    end else if (ld_i) begin
      entry_d = d_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q <= HzBubble;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: EX/MEM/WB shadow scoreboard, registered operand forwarding
// selects, load-use stall detection and a saturating stall-cycle counter.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RA_W    = RegAddrW,
  parameter int unsigned STALL_W = 16
) (
  input logic             clk,
  input logic             reset,
  ex_hazard_ctrl_if.slave bus
);

  hz_entry_t          ex_q, mem_q, wb_q;
  hz_entry_t          id_ent;
  logic [RA_W-1:0]    rs1, rs2;
  logic               load_use, stall, issue;
  fwd_sel_e           sel_a_d, sel_a_q, sel_b_d, sel_b_q;
  logic [STALL_W-1:0] stall_cnt_d, stall_cnt_q;
  logic               unused_fields;

  assign rs1 = bus.id_rs1;
  assign rs2 = bus.id_rs2;

  always_comb begin
    id_ent         = HzBubble;
    id_ent.v       = 1'b1;
    id_ent.rd      = bus.id_rd;
    id_ent.wr_rd   = bus.id_wr_rd;
    id_ent.is_load = bus.id_is_load;
    id_ent.wr_ccr  = bus.id_wr_ccr;
  end

  assign load_use = bus.id_valid & ex_q.v & ex_q.is_load & ex_q.wr_rd &
                    ((bus.id_use_rs1 & (rs1 == ex_q.rd)) | (bus.id_use_rs2 & (rs2 == ex_q.rd)));
  // A taken branch kills the decode slot, so it never stalls.
  assign stall    = load_use & ~bus.flush;
  assign issue    = bus.id_valid & ~stall & ~bus.flush;

  hz_shadow_stage u_ex (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (~issue),
    .ld_i  (1'b1),
    .d_i   (id_ent),
    .q_o   (ex_q)
  );

  hz_shadow_stage u_mem (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (1'b0),
    .ld_i  (1'b1),
    .d_i   (ex_q),
    .q_o   (mem_q)
  );

  hz_shadow_stage u_wb (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (1'b0),
    .ld_i  (1'b1),
    .d_i   (mem_q),
    .q_o   (wb_q)
  );

  always_comb begin
    sel_a_d     = FwdNone;
    sel_b_d     = FwdNone;
    stall_cnt_d = stall_cnt_q;
    if (issue) begin
      sel_a_d = fwd_pick(rs1, bus.id_use_rs1, ex_q, mem_q, wb_q);
      sel_b_d = fwd_pick(rs2, bus.id_use_rs2, ex_q, mem_q, wb_q);
    end
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_a_q     <= FwdNone;
      sel_b_q     <= FwdNone;
      stall_cnt_q <= '0;
    end else begin
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ex_fwd_sel_a = sel_a_q;
  assign bus.ex_fwd_sel_b = sel_b_q;
  assign bus.ex_ccr_write = ex_q.v & ex_q.wr_ccr;
  assign bus.id_stall     = stall;
  assign bus.ex_bubble    = ~ex_q.v;
  assign bus.stall_count  = stall_cnt_q;

  // Older stages only feed forwarding; their load/CCR flags have no consumer.
  assign unused_fields = ^{mem_q.is_load, mem_q.wr_ccr, wb_q.is_load, wb_q.wr_ccr};

endmodule
